// File: rtl/chkseq_pkg.sv
// rtl/chkseq_pkg.sv - shared types and constants for the checkpoint sequencer
package chkseq_pkg;

    // Widest checkpoint ID the tracker record can hold; replica_width must not exceed it
    localparam int CHKSEQ_ID_W_MAX = 8;

    typedef logic [CHKSEQ_ID_W_MAX-1:0] chk_id_t;

    // One tracker slot, head of the age order is the oldest live checkpoint
    typedef struct packed {
        logic    valid;
        chk_id_t id;
        logic    resolved;
        logic    mispred;
    } chk_entry_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } seq_state_e;

    // {DO_REL, DO_ROLL} command encodings sent to the register file
    typedef logic [1:0] chk_cmd_t;
    localparam chk_cmd_t CMD_NONE     = 2'b00;
    localparam chk_cmd_t CMD_RELEASE  = 2'b10;
    localparam chk_cmd_t CMD_ROLLBACK = 2'b11;

    function automatic chk_cmd_t head_cmd(input logic rollbk, input logic mispred);
        if (!rollbk) begin
            return CMD_NONE;
        end
        return mispred ? CMD_ROLLBACK : CMD_RELEASE;
    endfunction

endpackage

// File: rtl/chkseq_age_table.sv
// rtl/chkseq_age_table.sv - age-ordered checkpoint tracker with associative resolve
module chkseq_age_table
    import chkseq_pkg::*;
#(
    parameter int replica_width = 2,
    parameter int num_replicas  = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [replica_width-1:0] push_id_i,
    input  logic                     resolve_i,
    input  logic [replica_width-1:0] resolve_id_i,
    input  logic                     resolve_mispred_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic                     head_valid_o,
    output logic [replica_width-1:0] head_id_o,
    output logic                     head_resolved_o,
    output logic                     head_mispred_o,
    output logic [replica_width:0]   count_o,
    output logic                     full_o
);

    localparam int PTR_W = (num_replicas > 1) ? $clog2(num_replicas) : 1;
    localparam int CNT_W = replica_width + 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(num_replicas - 1);

    chk_entry_t       entries_q [num_replicas];
    chk_entry_t       entries_d [num_replicas];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Next-state: flush wins outright; otherwise resolve, pop and push apply together
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (flush_i) begin
            for (int i = 0; i < num_replicas; i++) begin
                entries_d[i] = '0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            for (int i = 0; i < num_replicas; i++) begin
                if (resolve_i && entries_q[i].valid &&
                    entries_q[i].id == chk_id_t'(resolve_id_i)) begin
                    entries_d[i].resolved = 1'b1;
                    entries_d[i].mispred  = resolve_mispred_i;
                end
                if (pop_i && PTR_W'(i) == head_q) begin
                    entries_d[i] = '0;
                end
                if (push_i && PTR_W'(i) == tail_q) begin
                    entries_d[i] = '{valid: 1'b1, id: chk_id_t'(push_id_i),
                                     resolved: 1'b0, mispred: 1'b0};
                end
            end
            if (pop_i) begin
                head_d = ptr_inc(head_q);
            end
            if (push_i) begin
                tail_d = ptr_inc(tail_q);
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Tracker state registers, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < num_replicas; i++) begin
                entries_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    assign head_valid_o    = entries_q[head_q].valid;
    assign head_id_o       = entries_q[head_q].id[replica_width-1:0];
    assign head_resolved_o = entries_q[head_q].resolved;
    assign head_mispred_o  = entries_q[head_q].mispred;
    assign count_o         = count_q;
    assign full_o          = (count_q == CNT_W'(num_replicas));

endmodule

// File: rtl/checkpoint_sequencer.sv
// rtl/checkpoint_sequencer.sv - checkpoint alloc/retire sequencer; CHKSEQ_STATS_EN enables commit/squash counters
module checkpoint_sequencer
    import chkseq_pkg::*;
#(
    parameter int replica_width = 2,
    parameter int num_replicas  = 4
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     ALLOC_REQ,
    output logic                     ALLOC_GNT,
    output logic [replica_width-1:0] ALLOC_ID,
    input  logic                     CHK_READY,
    input  logic [replica_width-1:0] CHK_IN,
    output logic                     CHK_E,
    input  logic                     RESOLVE_E,
    input  logic [replica_width-1:0] RESOLVE_ID,
    input  logic                     RESOLVE_MISPRED,
    output logic                     ROLLBK_E,
    output logic                     DO_ROLL,
    output logic                     DO_REL,
    output logic [replica_width-1:0] ROLLBK_ID,
    output logic                     SQUASH,
    output logic [replica_width:0]   OUTSTANDING,
    output logic [15:0]              NUM_COMMIT,
    output logic [15:0]              NUM_SQUASH
);

    seq_state_e               state_q;
    logic                     run;
    logic                     head_valid;
    logic [replica_width-1:0] head_id;
    logic                     head_resolved;
    logic                     head_mispred;
    logic [replica_width:0]   count;
    logic                     full;
    logic                     rollbk;
    logic                     alloc_gnt;
    logic                     pop;
    logic                     squash;
    chk_cmd_t                 cmd;

    assign run = (state_q == ST_RUN);

    // Rollback is decoded purely from registered tracker state, so it lags a head resolve by one cycle
    assign rollbk = run & head_valid & head_resolved;
    assign cmd    = head_cmd(rollbk, head_mispred);
    assign pop    = rollbk & ~head_mispred;
    assign squash = rollbk & head_mispred;

    // Rollback owns the register-file port, so it blocks any grant in the same cycle
    assign alloc_gnt = RST_N & ALLOC_REQ & CHK_READY & ~full & ~rollbk & run;

    chkseq_age_table #(
        .replica_width (replica_width),
        .num_replicas  (num_replicas)
    ) u_age_table (
        .clk_i             (CLK),
        .rst_ni            (RST_N),
        .push_i            (alloc_gnt),
        .push_id_i         (CHK_IN),
        .resolve_i         (RESOLVE_E & run),
        .resolve_id_i      (RESOLVE_ID),
        .resolve_mispred_i (RESOLVE_MISPRED),
        .pop_i             (pop),
        .flush_i           (squash),
        .head_valid_o      (head_valid),
        .head_id_o         (head_id),
        .head_resolved_o   (head_resolved),
        .head_mispred_o    (head_mispred),
        .count_o           (count),
        .full_o            (full)
    );

    // Sequencer FSM: a squash parks for exactly one FLUSH cycle before resuming
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_RUN;
        end else begin
            case (state_q)
                ST_RUN:   state_q <= squash ? ST_FLUSH : ST_RUN;
                ST_FLUSH: state_q <= ST_RUN;
                default:  state_q <= ST_RUN;
            endcase
        end
    end

    assign ALLOC_GNT   = alloc_gnt;
    assign CHK_E       = alloc_gnt;
    assign ALLOC_ID    = CHK_IN;
    assign ROLLBK_E    = rollbk;
    assign ROLLBK_ID   = rollbk ? head_id : '0;
    assign DO_REL      = cmd[1];
    assign DO_ROLL     = cmd[0];
    assign SQUASH      = squash;
    assign OUTSTANDING = count;

`ifdef CHKSEQ_STATS_EN
    logic [15:0] num_commit_q;
    logic [15:0] num_squash_q;

    // Saturating retirement statistics
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            num_commit_q <= '0;
            num_squash_q <= '0;
        end else begin
            if (pop && num_commit_q != 16'hFFFF) begin
                num_commit_q <= num_commit_q + 16'd1;
            end
            if (squash && num_squash_q != 16'hFFFF) begin
                num_squash_q <= num_squash_q + 16'd1;
            end
        end
    end

    assign NUM_COMMIT = num_commit_q;
    assign NUM_SQUASH = num_squash_q;
`else
    assign NUM_COMMIT = '0;
    assign NUM_SQUASH = '0;
`endif

endmodule

// File: tb/tb_checkpoint_sequencer.sv
// tb/tb_checkpoint_sequencer.sv - scoreboard bench for checkpoint_sequencer
module tb_checkpoint_sequencer;

    localparam int RW = 2;
    localparam int NR = 4;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          ALLOC_REQ;
    logic          ALLOC_GNT;
    logic [RW-1:0] ALLOC_ID;
    logic          CHK_READY;
    logic [RW-1:0] CHK_IN;
    logic          CHK_E;
    logic          RESOLVE_E;
    logic [RW-1:0] RESOLVE_ID;
    logic          RESOLVE_MISPRED;
    logic          ROLLBK_E;
    logic          DO_ROLL;
    logic          DO_REL;
    logic [RW-1:0] ROLLBK_ID;
    logic          SQUASH;
    logic [RW:0]   OUTSTANDING;
    logic [15:0]   NUM_COMMIT;
    logic [15:0]   NUM_SQUASH;

    int         n_total = 0;
    int         n_bad   = 0;
    int         exp_commit = 0;
    int         exp_squash = 0;
    logic [7:0] exp_q[$];

    always #5 CLK = ~CLK;

    checkpoint_sequencer #(.replica_width(RW), .num_replicas(NR)) dut (
        .CLK             (CLK),
        .RST_N           (RST_N),
        .ALLOC_REQ       (ALLOC_REQ),
        .ALLOC_GNT       (ALLOC_GNT),
        .ALLOC_ID        (ALLOC_ID),
        .CHK_READY       (CHK_READY),
        .CHK_IN          (CHK_IN),
        .CHK_E           (CHK_E),
        .RESOLVE_E       (RESOLVE_E),
        .RESOLVE_ID      (RESOLVE_ID),
        .RESOLVE_MISPRED (RESOLVE_MISPRED),
        .ROLLBK_E        (ROLLBK_E),
        .DO_ROLL         (DO_ROLL),
        .DO_REL          (DO_REL),
        .ROLLBK_ID       (ROLLBK_ID),
        .SQUASH          (SQUASH),
        .OUTSTANDING     (OUTSTANDING),
        .NUM_COMMIT      (NUM_COMMIT),
        .NUM_SQUASH      (NUM_SQUASH)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] stat(input int v);
`ifdef CHKSEQ_STATS_EN
        return 16'(v);
`else
        return 16'(v) & 16'h0000;
`endif
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Expected retirement record: {pad, id, DO_REL, DO_ROLL, SQUASH}
    task automatic expect_ret(input logic [RW-1:0] id, input logic mis);
        exp_q.push_back({3'b000, id, 1'b1, mis, mis});
        if (mis) exp_squash++;
        else     exp_commit++;
    endtask

    task automatic alloc(input logic [RW-1:0] id);
        ALLOC_REQ = 1'b1;
        CHK_READY = 1'b1;
        CHK_IN    = id;
        #1;
        chk("alloc_gnt", 32'(ALLOC_GNT), 32'd1);
        chk("alloc_chk_e", 32'(CHK_E), 32'd1);
        chk("alloc_id", 32'(ALLOC_ID), 32'(id));
        tick();
        ALLOC_REQ = 1'b0;
    endtask

    task automatic resolve(input logic [RW-1:0] id, input logic mis);
        RESOLVE_E       = 1'b1;
        RESOLVE_ID      = id;
        RESOLVE_MISPRED = mis;
        tick();
        RESOLVE_E       = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 20 && OUTSTANDING != 0; k++) tick();
        tick();
        chk(tag, 32'(OUTSTANDING), 32'd0);
    endtask

    // Scoreboard monitor: every rollback command must match the oldest expected retirement
    always @(negedge CLK) begin
        if (RST_N && ROLLBK_E) begin
            if (exp_q.size() == 0) begin
                chk("rollbk_unexpected", 32'(ROLLBK_E), 32'd0);
            end else begin
                chk("retire", 32'({3'b000, ROLLBK_ID, DO_REL, DO_ROLL, SQUASH}),
                    32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N = 1'b0;
        ALLOC_REQ = 1'b1;
        CHK_READY = 1'b1;
        CHK_IN = 2'd2;
        RESOLVE_E = 1'b0;
        RESOLVE_ID = '0;
        RESOLVE_MISPRED = 1'b0;
        #1;
        chk("rst_gnt", 32'(ALLOC_GNT), 32'd0);
        chk("rst_chk_e", 32'(CHK_E), 32'd0);
        chk("rst_alloc_id", 32'(ALLOC_ID), 32'd2);
        chk("rst_rollbk", 32'(ROLLBK_E), 32'd0);
        chk("rst_outstanding", 32'(OUTSTANDING), 32'd0);
        chk("rst_commit", 32'(NUM_COMMIT), 32'd0);
        tick();
        tick();
        ALLOC_REQ = 1'b0;
        RST_N = 1'b1;
        tick();

        // Out-of-order resolves retire in age order on consecutive cycles
        alloc(2'd0); alloc(2'd1); alloc(2'd2);
        chk("s1_outstanding", 32'(OUTSTANDING), 32'd3);
        resolve(2'd2, 1'b0);
        chk("s1_wait2", 32'(ROLLBK_E), 32'd0);
        resolve(2'd1, 1'b0);
        chk("s1_wait1", 32'(ROLLBK_E), 32'd0);
        expect_ret(2'd0, 1'b0); expect_ret(2'd1, 1'b0); expect_ret(2'd2, 1'b0);
        resolve(2'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk("s1_rollbk", 32'(ROLLBK_E), 32'd1);
            chk("s1_cmd", 32'({DO_REL, DO_ROLL}), 32'b10);
            tick();
        end
        chk("s1_idle", 32'(ROLLBK_E), 32'd0);
        chk("s1_empty", 32'(OUTSTANDING), 32'd0);
        chk("s1_sb", 32'(exp_q.size()), 32'd0);
        chk("s1_commit", 32'(NUM_COMMIT), 32'(stat(exp_commit)));

        // Full tracker blocks grants until the first pop
        alloc(2'd0); alloc(2'd1); alloc(2'd2); alloc(2'd3);
        chk("s2_peak", 32'(OUTSTANDING), 32'd4);
        ALLOC_REQ = 1'b1; CHK_READY = 1'b1; CHK_IN = 2'd0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("s2_full_gnt", 32'(ALLOC_GNT), 32'd0);
            tick();
        end
        expect_ret(2'd0, 1'b0);
        RESOLVE_E = 1'b1; RESOLVE_ID = 2'd0; RESOLVE_MISPRED = 1'b0;
        #1;
        chk("s2_res_gnt", 32'(ALLOC_GNT), 32'd0);
        tick();
        RESOLVE_E = 1'b0;
        chk("s2_rb_rollbk", 32'(ROLLBK_E), 32'd1);
        chk("s2_rb_chk_e", 32'(CHK_E), 32'd0);
        tick();
        chk("s2_after_pop_gnt", 32'(CHK_E), 32'd1);
        tick();
        ALLOC_REQ = 1'b0;
        chk("s2_refull", 32'(OUTSTANDING), 32'd4);
        expect_ret(2'd1, 1'b0); expect_ret(2'd2, 1'b0);
        expect_ret(2'd3, 1'b0); expect_ret(2'd0, 1'b0);
        resolve(2'd1, 1'b0); resolve(2'd2, 1'b0);
        resolve(2'd3, 1'b0); resolve(2'd0, 1'b0);
        drain("s2_drain");
        chk("s2_sb", 32'(exp_q.size()), 32'd0);

        // Alloc request colliding with a head retirement waits one cycle
        alloc(2'd1);
        expect_ret(2'd1, 1'b0);
        resolve(2'd1, 1'b0);
        ALLOC_REQ = 1'b1; CHK_READY = 1'b1; CHK_IN = 2'd2;
        #1;
        chk("s4_collide_chk_e", 32'(CHK_E), 32'd0);
        tick();
        chk("s4_next_chk_e", 32'(CHK_E), 32'd1);
        tick();
        ALLOC_REQ = 1'b0;
        chk("s4_outstanding", 32'(OUTSTANDING), 32'd1);
        expect_ret(2'd2, 1'b0);
        resolve(2'd2, 1'b0);
        drain("s4_drain");

        // Mispredicted head squashes everything; a resolve of a squashed entry is dropped
        alloc(2'd0); alloc(2'd1); alloc(2'd2);
        expect_ret(2'd0, 1'b1);
        resolve(2'd0, 1'b1);
        RESOLVE_E = 1'b1; RESOLVE_ID = 2'd1; RESOLVE_MISPRED = 1'b0;
        ALLOC_REQ = 1'b1; CHK_READY = 1'b1; CHK_IN = 2'd1;
        #1;
        chk("s3_rollbk", 32'(ROLLBK_E), 32'd1);
        chk("s3_id", 32'(ROLLBK_ID), 32'd0);
        chk("s3_cmd", 32'({DO_REL, DO_ROLL}), 32'b11);
        chk("s3_squash", 32'(SQUASH), 32'd1);
        chk("s3_gnt", 32'(ALLOC_GNT), 32'd0);
        tick();
        RESOLVE_ID = 2'd2;
        chk("s3_flush_gnt", 32'(ALLOC_GNT), 32'd0);
        chk("s3_flush_rollbk", 32'(ROLLBK_E), 32'd0);
        chk("s3_flush_out", 32'(OUTSTANDING), 32'd0);
        chk("s3_flush_sq", 32'(SQUASH), 32'd0);
        chk("s3_num_squash", 32'(NUM_SQUASH), 32'(stat(exp_squash)));
        tick();
        RESOLVE_E = 1'b0;
        chk("s3_run_gnt", 32'(ALLOC_GNT), 32'd1);
        tick();
        ALLOC_REQ = 1'b0;
        chk("s3_realloc", 32'(OUTSTANDING), 32'd1);
        tick();
        chk("s3_dropped_res", 32'(ROLLBK_E), 32'd0);

        // Resolve of an absent ID is a no-op
        resolve(2'd3, 1'b0);
        chk("s5_nomatch_rb", 32'(ROLLBK_E), 32'd0);
        chk("s5_nomatch_out", 32'(OUTSTANDING), 32'd1);
        tick();
        chk("s5_nomatch_rb2", 32'(ROLLBK_E), 32'd0);

        // Asynchronous reset mid-sequence clears outputs at once and discards the pending resolve
        alloc(2'd2);
        chk("s5_pre_rst_out", 32'(OUTSTANDING), 32'd2);
        RESOLVE_E = 1'b1; RESOLVE_ID = 2'd1; RESOLVE_MISPRED = 1'b0;
        ALLOC_REQ = 1'b1; CHK_READY = 1'b1; CHK_IN = 2'd3;
        #2;
        RST_N = 1'b0;
        #1;
        chk("s5_rst_gnt", 32'(ALLOC_GNT), 32'd0);
        chk("s5_rst_chk_e", 32'(CHK_E), 32'd0);
        chk("s5_rst_alloc_id", 32'(ALLOC_ID), 32'd3);
        chk("s5_rst_rollbk", 32'(ROLLBK_E), 32'd0);
        chk("s5_rst_rel", 32'(DO_REL), 32'd0);
        chk("s5_rst_sq", 32'(SQUASH), 32'd0);
        chk("s5_rst_out", 32'(OUTSTANDING), 32'd0);
        chk("s5_rst_commit", 32'(NUM_COMMIT), 32'd0);
        chk("s5_rst_squash", 32'(NUM_SQUASH), 32'd0);
        tick();
        tick();
        RST_N = 1'b1;
        ALLOC_REQ = 1'b0;
        RESOLVE_E = 1'b0;
        tick();
        chk("s5_post_rollbk", 32'(ROLLBK_E), 32'd0);
        chk("s5_post_out", 32'(OUTSTANDING), 32'd0);
        chk("final_sb", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
